// File: rtl/vreg_pkg.sv
// rtl/vreg_pkg.sv - shared vector register file types, widths and arbiter states
package vreg_pkg;

  localparam int VREG_DATA_W = 128;
  localparam int VREG_ADDR_W = 4;

  typedef logic [VREG_ADDR_W-1:0] vreg_addr_t;
  typedef logic [VREG_DATA_W-1:0] vreg_data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    STALL = 2'd2
  } warb_state_t;

  // Index of the requester after idx, wrapping at n.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/vreg_write_arbiter_if.sv
// rtl/vreg_write_arbiter_if.sv - requester handshakes and register file write port
interface vreg_write_arbiter_if
  import vreg_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = VREG_DATA_W,
  parameter int ADDR_W  = VREG_ADDR_W,
  localparam int GID_W  = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      wr_stall;
  logic                      flush;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic [GID_W-1:0]          grant_id;
  logic                      busy;

  modport master (
    output req_valid, req_addr, req_data, wr_stall, flush,
    input  req_ready, wr_en, wr_addr, wr_data, grant_id, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data, wr_stall, flush,
    output req_ready, wr_en, wr_addr, wr_data, grant_id, busy
  );

endinterface

// File: rtl/vreg_write_arbiter_rr_pick.sv
// rtl/vreg_write_arbiter_rr_pick.sv - combinational round-robin one-hot picker
module rr_pick #(
  parameter int  N  = 3,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [PW-1:0] i_ptr,
  input  logic          i_en,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx
);

  function automatic logic [PW-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    return PW'((s >= N) ? s - N : s);
  endfunction

  // Scan from the farthest candidate back to i_ptr so the nearest valid one wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_en && i_valid[wrap_idx(int'(i_ptr), k)]) begin
        o_grant                             = '0;
        o_grant[wrap_idx(int'(i_ptr), k)]   = 1'b1;
        o_idx                               = wrap_idx(int'(i_ptr), k);
      end
    end
  end

endmodule

// File: rtl/vreg_write_arbiter.sv
// rtl/vreg_write_arbiter.sv - round-robin arbiter for the vector register file write port; VREG_WARB_STATS_EN adds per-requester grant counters
module vreg_write_arbiter
  import vreg_pkg::*;
#(
  parameter int  NUM_REQ = 3,
  parameter int  DATA_W  = VREG_DATA_W,
  parameter int  ADDR_W  = VREG_ADDR_W,
  localparam int GID_W   = $clog2(NUM_REQ)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  vreg_write_arbiter_if.slave     bus
`ifdef VREG_WARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]   o_grant_count
`endif
);

  warb_state_t        r_state;
  warb_state_t        w_state_nxt;
  logic [GID_W-1:0]   r_rr_ptr;
  logic [GID_W-1:0]   w_idx;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_can_accept;
  logic               w_xfer;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [DATA_W-1:0]  r_wr_data;
  logic [GID_W-1:0]   r_grant_id;

  // A held (stalled) write blocks new grants, as does a write the file is refusing now.
  assign w_can_accept = !i_rst && !bus.flush && (r_state != STALL)
                        && !((r_state == WRITE) && bus.wr_stall);

  rr_pick #(.N(NUM_REQ)) u_pick (
    .i_valid (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .i_en    (w_can_accept),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign w_xfer        = |w_grant;
  assign bus.req_ready = w_grant;
  assign bus.wr_en     = (r_state != IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.grant_id  = r_grant_id;

  // Next state: flush wins over stall; a stalled write leaves as soon as stall drops.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_xfer) w_state_nxt = WRITE;
        WRITE: begin
          if (bus.wr_stall)  w_state_nxt = STALL;
          else if (w_xfer)   w_state_nxt = WRITE;
          else               w_state_nxt = IDLE;
        end
        STALL:   if (!bus.wr_stall) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Capture the granted write and move the round-robin pointer past the winner.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
    end else if (w_xfer) begin
      r_wr_addr  <= ADDR_W'(bus.req_addr >> (int'(w_idx) * ADDR_W));
      r_wr_data  <= DATA_W'(bus.req_data >> (int'(w_idx) * DATA_W));
      r_grant_id <= w_idx;
      r_rr_ptr   <= GID_W'(rr_wrap(int'(w_idx), NUM_REQ));
    end
  end

`ifdef VREG_WARB_STATS_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
    logic [15:0] r_cnt;
    // Saturating transfer count; flush cycles never grant, so they never count.
    always_ff @(posedge i_clk) begin
      if (i_rst)                              r_cnt <= '0;
      else if (w_grant[gi] && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end
    assign o_grant_count[gi*16 +: 16] = r_cnt;
  end
`endif

endmodule

// File: tb/tb_vreg_write_arbiter.sv
// tb/tb_vreg_write_arbiter.sv - directed and random checks of vreg_write_arbiter against a behavioural model (VREG_WARB_STATS_EN adds counter checks)
module tb_vreg_write_arbiter;
  import vreg_pkg::*;

  localparam int N  = 3;
  localparam int AW = VREG_ADDR_W;
  localparam int DW = VREG_DATA_W;
  localparam int GW = $clog2(N);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vreg_write_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus ();
`ifdef VREG_WARB_STATS_EN
  logic [N*16-1:0] grant_count;
`endif

  vreg_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
`ifdef VREG_WARB_STATS_EN
    ,
    .o_grant_count (grant_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Model: the write presented on the port, whether it was refused last cycle, rr pointer.
  bit         m_ov;
  bit         m_held;
  int         m_ptr;
  vreg_addr_t m_addr;
  vreg_data_t m_data;
  int         m_gid;
  int         m_cnt [N];

  vreg_addr_t q_addr [N];
  vreg_data_t q_data [N];
  logic [N-1:0] obs_ready;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ov = 0; m_held = 0; m_ptr = 0; m_addr = '0; m_data = '0; m_gid = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic set_req(input int i, input int a, input int d);
    q_addr[i] = vreg_addr_t'(a);
    q_data[i] = vreg_data_t'(d);
  endtask

  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // One clock: drive inputs, check outputs and ready against the model, advance.
  task automatic cyc(input logic [N-1:0] v, input logic st, input logic fl, input logic rs);
    int g;
    logic [N-1:0] er;
    logic [N*AW-1:0] pa;
    logic [N*DW-1:0] pd;
    pa = '0;
    pd = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pa = (pa << AW) | (N*AW)'(q_addr[i]);
      pd = (pd << DW) | (N*DW)'(q_data[i]);
    end
    rst = rs; bus.req_valid = v; bus.wr_stall = st; bus.flush = fl;
    bus.req_addr = pa; bus.req_data = pd;
    #1;
    chk("wr_en",    DW'(bus.wr_en),    DW'(m_ov));
    chk("busy",     DW'(bus.busy),     DW'(m_ov));
    chk("wr_addr",  DW'(bus.wr_addr),  DW'(m_addr));
    chk("wr_data",  bus.wr_data,       m_data);
    chk("grant_id", DW'(bus.grant_id), DW'(m_gid));
    g  = -1;
    er = '0;
    if (!(rs || fl || m_held || (m_ov && st))) begin
      g = pick(v);
      if (g >= 0) er = N'(1) << g;
    end
    obs_ready = bus.req_ready;
    chk("req_ready", DW'(bus.req_ready), DW'(er));
`ifdef VREG_WARB_STATS_EN
    for (int i = 0; i < N; i++)
      chk($sformatf("grant_count%0d", i), DW'(16'(grant_count >> (16*i))), DW'(16'(m_cnt[i])));
`endif
    if (rs) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        m_addr = q_addr[g]; m_data = q_data[g]; m_gid = g; m_ptr = (g + 1) % N;
        if (m_cnt[g] < 65535) m_cnt[g]++;
        q_addr[g] = vreg_addr_t'($urandom);
        q_data[g] = {$urandom, $urandom, $urandom, $urandom};
      end
      if (fl) begin
        m_ov = 0; m_held = 0;
      end else if (m_ov && st) begin
        m_held = 1;
      end else if (m_held) begin
        m_ov = 0; m_held = 0;
      end else begin
        m_ov = (g >= 0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = '0; bus.wr_stall = 1'b0; bus.flush = 1'b0;
    bus.req_addr = '0; bus.req_data = '0;
    model_reset();
    for (int i = 0; i < N; i++) set_req(i, i + 1, 100 + i);
    @(posedge clk);
    #1;

    // reset held two cycles with requests pending
    cyc(3'b111, 0, 0, 1);
    chk("rst_ready", DW'(obs_ready), DW'(3'b000));
    cyc(3'b111, 0, 0, 1);
    chk("rst_wr_en", DW'(bus.wr_en), DW'(1'b0));
    chk("rst_busy",  DW'(bus.busy),  DW'(1'b0));
    cyc(3'b000, 0, 0, 0);
    chk("idle_busy", DW'(bus.busy),  DW'(1'b0));

    // single requester
    set_req(1, 5, 678);
    cyc(3'b010, 0, 0, 0);
    chk("single_ready", DW'(obs_ready),    DW'(3'b010));
    chk("single_wr_en", DW'(bus.wr_en),    DW'(1'b1));
    chk("single_addr",  DW'(bus.wr_addr),  DW'(5));
    chk("single_data",  bus.wr_data,       DW'(678));
    chk("single_gid",   DW'(bus.grant_id), DW'(1));
    cyc(3'b000, 0, 0, 0);
    chk("single_drop",  DW'(bus.wr_en),    DW'(1'b0));

    // round robin with all requesters valid
    cyc(3'b000, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(3'b111, 0, 0, 0);
      chk("rr_ready", DW'(obs_ready),    DW'(3'b001 << (k % 3)));
      chk("rr_wr_en", DW'(bus.wr_en),    DW'(1'b1));
      chk("rr_gid",   DW'(bus.grant_id), DW'(k % 3));
    end

    // stall holds the write for three cycles, then arbitration resumes at requester 1
    cyc(3'b000, 0, 0, 1);
    set_req(0, 3, 25);
    cyc(3'b001, 0, 0, 0);
    for (int s = 0; s < 3; s++) begin
      cyc(3'b110, 1, 0, 0);
      chk("stall_ready", DW'(obs_ready),   DW'(3'b000));
      chk("stall_wr_en", DW'(bus.wr_en),   DW'(1'b1));
      chk("stall_addr",  DW'(bus.wr_addr), DW'(3));
      chk("stall_data",  bus.wr_data,      DW'(25));
    end
    cyc(3'b110, 0, 0, 0);
    chk("unstall_ready", DW'(obs_ready), DW'(3'b000));
    chk("unstall_done",  DW'(bus.wr_en), DW'(1'b0));
    cyc(3'b110, 0, 0, 0);
    chk("resume_ready",  DW'(obs_ready), DW'(3'b010));

    // flush drops a pending write and blocks that cycle's grant
    cyc(3'b000, 0, 0, 1);
    set_req(2, 7, 123);
    cyc(3'b100, 0, 0, 0);
    chk("flush_pend_addr", DW'(bus.wr_addr), DW'(7));
    cyc(3'b001, 0, 1, 0);
    chk("flush_ready", DW'(obs_ready),    DW'(3'b000));
    chk("flush_wr_en", DW'(bus.wr_en),    DW'(1'b0));
    cyc(3'b001, 0, 0, 0);
    chk("post_flush_ready", DW'(obs_ready),    DW'(3'b001));
    chk("post_flush_gid",   DW'(bus.grant_id), DW'(0));

`ifdef VREG_WARB_STATS_EN
    cyc(3'b000, 0, 0, 1);
    for (int k = 0; k < 5; k++) cyc(3'b100, 0, 0, 0);
    chk("stats_r0", DW'(grant_count[15:0]),  DW'(0));
    chk("stats_r1", DW'(grant_count[31:16]), DW'(0));
    chk("stats_r2", DW'(grant_count[47:32]), DW'(5));
    cyc(3'b000, 0, 0, 1);
    chk("stats_clr", DW'(grant_count), DW'(0));
`endif

    // random traffic with stalls, flushes and occasional resets
    for (int n = 0; n < 500; n++) begin
      cyc(N'($urandom), ($urandom % 4) == 0, ($urandom % 12) == 0, ($urandom % 60) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vreg_write_arbiter.md
Name: vreg_write_arbiter

Overview:
- Shares the single 128-bit write port of the vector register file between NUM_REQ producers: ALU, load unit and interpolation unit.
- Arbitration is round-robin with a valid/ready handshake on each requester.
- The winning write is registered one cycle before it reaches the register file.
- Sits between execute/memory stages and the register file (syncRegister-based storage); honours back-pressure (wr_stall) and pipeline flush.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- DATA_W, 128, write data width
- ADDR_W, 4, register index width (16 vector registers)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester write request
- req_addr  input  NUM_REQ*ADDR_W  packed destination indices; requester i at [i*ADDR_W +: ADDR_W]
- req_data  input  NUM_REQ*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W]
- req_ready  output  NUM_REQ  one-hot grant/accept, combinational
- wr_stall  input  1  register file cannot take a write this cycle
- flush  input  1  drop pending output write; accept nothing this cycle
- wr_en  output  1  write strobe to register file
- wr_addr  output  ADDR_W  write index
- wr_data  output  DATA_W  write data
- grant_id  output  $clog2(NUM_REQ)  requester that produced the current wr_en write
- busy  output  1  high when state != IDLE

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, wr_en=0, wr_addr=0, wr_data=0, grant_id=0, rr_ptr=0. req_ready=0 while rst=1. Reset mid-stall discards the held write.
- Handshake: transfer occurs when req_valid[i] & req_ready[i]. Requesters must hold addr/data stable while valid and not ready. req_ready never depends on req_data or req_addr.
- Grant (combinational):
  - can_accept = !rst & !flush & !(state==STALL) & !(state==WRITE & wr_stall).
  - When can_accept, req_ready is one-hot on the first valid requester scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - Otherwise req_ready=0.
- Latency: an accepted request appears on wr_en/wr_addr/wr_data/grant_id on the next cycle (1 cycle).
- Round robin: on a transfer by requester g, rr_ptr <= (g+1) mod NUM_REQ. With no transfer, rr_ptr is unchanged.
- FSM states:
  - IDLE: no pending write. On transfer -> WRITE.
  - WRITE: wr_en=1; the register file takes the write this cycle unless wr_stall=1.
    - wr_stall=1 -> STALL, outputs held.
    - else transfer -> WRITE with new data (back-to-back, one write per cycle).
    - else -> IDLE.
  - STALL: wr_en=1, outputs held unchanged, req_ready=0.
    - wr_stall=0 -> IDLE; the held write completes this cycle.
- Flush in any state: next state IDLE, wr_en=0, no transfer that cycle, rr_ptr unchanged. Flush has priority over wr_stall.
- Data/address outputs are not cleared on IDLE; only wr_en drops.
- Two requesters targeting the same address in consecutive cycles are written in grant order; no merging.

Optional Feature:
- Macro VREG_WARB_STATS_EN.
- Defined: adds output grant_count of width NUM_REQ*16 (packed like req_addr). Each entry counts transfers for its requester, saturates at 16'hFFFF, clears on rst, is unaffected by flush.
- Undefined: port and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package vreg_pkg:
  - VREG_DATA_W=128, VREG_ADDR_W=4
  - typedef vreg_addr_t, vreg_data_t
  - enum warb_state_t {IDLE, WRITE, STALL}
- Sub-module rr_pick: combinational round-robin priority picker (inputs valid vector, rr_ptr, enable; outputs one-hot grant and encoded index). Reusable by the future memory-port arbiter.

Test Plan:
- After rst held 2 cycles: wr_en=0, busy=0, req_ready=0; release rst with req_valid=3'b000 -> stays IDLE.
- Single requester: req_valid=3'b010, addr=5, data=128'd678 -> req_ready=3'b010 same cycle. Next cycle wr_en=1, wr_addr=5, wr_data=678, grant_id=1. The cycle after, wr_en=0.
- All three valid continuously from rr_ptr=0 -> grants 0,1,2,0 on four consecutive cycles with wr_en high every cycle and data matching each grant.
- wr_stall=1 while in WRITE with addr=3, data=25:
  - req_ready=0 and outputs hold 3/25 for 3 stall cycles.
  - Stall drops -> write completes, then arbitration resumes from the saved rr_ptr.
- flush asserted with a pending write (addr=7, data=123) and req_valid=3'b001 -> next cycle wr_en=0, no grant that cycle, requester 0 granted the following cycle.
- With VREG_WARB_STATS_EN: 5 grants to requester 2 -> grant_count[2]=5, others 0; rst clears all to 0.
